fsm_match_monitor: RTL and testbench

- Downstream consumer of the run-detector FSM's z flag and y state code.
- Classifies each match run as a zero-run (four or more 0s) or a one-run (four or more 1s), and counts each kind.
- Drives a pulse-stretched LED so that single-cycle matches are visible on the board.
- Sits between the detector and the board LEDs/7-seg display.

---
 rtl/fsm_mon_pkg.sv | 29 ++
 rtl/fsm_match_monitor_if.sv | 39 +++
 rtl/pulse_stretcher.sv | 39 +++
 rtl/fsm_match_monitor.sv | 141 ++++++++++++++
 tb/tb_fsm_match_monitor.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fsm_mon_pkg.sv
// Shared types and constants for the run-detector match monitor.
package fsm_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ZRUN,
        ORUN,
        BRUN
    } run_state_e;

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_ZERO = 2'b01;
    localparam logic [1:0] KIND_ONE  = 2'b10;
    localparam logic [1:0] KIND_UNCL = 2'b11;

    localparam logic [3:0] ZERO_CODE_DEF = 4'd4;
    localparam logic [3:0] ONE_CODE_DEF  = 4'd8;

    function automatic logic [1:0] kind_of(input run_state_e s);
        kind_of = KIND_NONE;
        unique case (s)
            IDLE: kind_of = KIND_NONE;
            ZRUN: kind_of = KIND_ZERO;
            ORUN: kind_of = KIND_ONE;
            BRUN: kind_of = KIND_UNCL;
        endcase
    endfunction

endpackage

// File: rtl/fsm_match_monitor_if.sv
// Detector-side inputs and board-side outputs of the match monitor.
// max_len exists only when MATCH_STATS_EN is defined.
interface fsm_match_monitor_if #(
    parameter int CNT_W = 8
);
    logic             z;
    logic [8:0]       y;
    logic             clr;
    logic [CNT_W-1:0] zero_cnt;
    logic [CNT_W-1:0] one_cnt;
    logic             match_led;
    logic [1:0]       match_kind;
    logic             err;
`ifdef MATCH_STATS_EN
    logic [CNT_W-1:0] max_len;

    modport master (
        output z, y, clr,
        input  zero_cnt, one_cnt, match_led,
        input  match_kind, err, max_len
    );
    modport slave (
        input  z, y, clr,
        output zero_cnt, one_cnt, match_led,
        output match_kind, err, max_len
    );
`else
    modport master (
        output z, y, clr,
        input  zero_cnt, one_cnt, match_led,
        input  match_kind, err
    );
    modport slave (
        input  z, y, clr,
        output zero_cnt, one_cnt, match_led,
        output match_kind, err
    );
`endif
endinterface

// File: rtl/pulse_stretcher.sv
// Retriggerable stretcher: out stays high HOLD_CYC cycles after trig.
module pulse_stretcher #(
    parameter int HOLD_CYC = 25000000,
    parameter int HOLD_W   = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    output logic out
);

    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              led_q, led_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        led_d = 1'b0;
        if (trig) begin
            cnt_d = HOLD_W'(HOLD_CYC - 1);
            led_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            led_d = 1'b1;
        end
    end

    assign out = led_q;

endmodule

// File: rtl/fsm_match_monitor.sv
// Classifies and counts detector match runs, drives a stretched LED.
// Optional MATCH_STATS_EN adds the longest-run tracker (max_len).
module fsm_match_monitor
    import fsm_mon_pkg::*;
#(
    parameter int         CNT_W     = 8,
    parameter int         HOLD_CYC  = 25000000,
    parameter int         HOLD_W    = 25,
    parameter logic [3:0] ZERO_CODE = ZERO_CODE_DEF,
    parameter logic [3:0] ONE_CODE  = ONE_CODE_DEF
) (
    input logic                clk,
    input logic                reset,
    fsm_match_monitor_if.slave mon
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]       y_dly_q;
    logic             z_dly_q, armed_q, rise_q;
    logic             armed_d, rise;
    run_state_e       state_q, state_d, cls;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [CNT_W-1:0] one_cnt_q, one_cnt_d;
    logic             err_q, err_d;
    logic             unused_y;

    assign unused_y = ^mon.y[8:4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_dly_q    <= '0;
            z_dly_q    <= 1'b0;
            armed_q    <= 1'b0;
            rise_q     <= 1'b0;
            state_q    <= IDLE;
            zero_cnt_q <= '0;
            one_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            y_dly_q    <= mon.y[3:0];
            z_dly_q    <= mon.z;
            armed_q    <= armed_d;
            rise_q     <= rise;
            state_q    <= state_d;
            zero_cnt_q <= zero_cnt_d;
            one_cnt_q  <= one_cnt_d;
            err_q      <= err_d;
        end
    end

    // z held high across reset release must be seen low before a rise counts
    always_comb begin
        armed_d = armed_q | ~mon.z;
        rise    = mon.z & ~z_dly_q & armed_q;
        unique case (1'b1)
            (y_dly_q == ZERO_CODE): cls = ZRUN;
            (y_dly_q == ONE_CODE):  cls = ORUN;
            default:                cls = BRUN;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:             if (rise)   state_d = cls;
            ZRUN, ORUN, BRUN: if (!mon.z) state_d = IDLE;
        endcase
    end

    always_comb begin
        zero_cnt_d = zero_cnt_q;
        one_cnt_d  = one_cnt_q;
        err_d      = err_q;
        if (mon.clr) begin
            zero_cnt_d = '0;
            one_cnt_d  = '0;
            err_d      = 1'b0;
        end else if (rise) begin
            unique case (cls)
                ZRUN: if (zero_cnt_q != CNT_MAX)
                    zero_cnt_d = zero_cnt_q + 1'b1;
                ORUN: if (one_cnt_q != CNT_MAX)
                    one_cnt_d = one_cnt_q + 1'b1;
                default: err_d = 1'b1;
            endcase
        end
    end

    pulse_stretcher #(
        .HOLD_CYC(HOLD_CYC),
        .HOLD_W  (HOLD_W)
    ) u_led (
        .clk  (clk),
        .reset(reset),
        .trig (rise_q),
        .out  (mon.match_led)
    );

    assign mon.zero_cnt   = zero_cnt_q;
    assign mon.one_cnt    = one_cnt_q;
    assign mon.err        = err_q;
    assign mon.match_kind = kind_of(state_q);

`ifdef MATCH_STATS_EN
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             run_exit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q <= '0;
            max_q <= '0;
        end else begin
            len_q <= len_d;
            max_q <= max_d;
        end
    end

    always_comb begin
        run_exit = (state_q != IDLE) & ~mon.z;
        len_d    = len_q;
        max_d    = max_q;
        if (run_exit) begin
            len_d = '0;
        end else if (rise) begin
            len_d = CNT_W'(1);
        end else if (state_q != IDLE && len_q != CNT_MAX) begin
            len_d = len_q + 1'b1;
        end
        if (mon.clr) begin
            max_d = '0;
        end else if (run_exit && len_q > max_q) begin
            max_d = len_q;
        end
    end

    assign mon.max_len = max_q;
`endif

endmodule

// File: tb/tb_fsm_match_monitor.sv
// Scoreboard bench for fsm_match_monitor (HOLD_CYC=10, CNT_W=8).
// Checks max_len too when MATCH_STATS_EN is defined.
module tb_fsm_match_monitor;

    localparam int CNT_W    = 8;
    localparam int HOLD_CYC = 10;
    localparam int HOLD_W   = 4;
    localparam int CMAX     = 255;

    typedef struct {
        int zc;
        int oc;
        int led;
        int kind;
        int err;
        int mx;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fsm_match_monitor_if #(.CNT_W(CNT_W)) bus ();

    fsm_match_monitor #(
        .CNT_W   (CNT_W),
        .HOLD_CYC(HOLD_CYC),
        .HOLD_W  (HOLD_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mon  (bus)
    );

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    int m_yd, m_zd, m_armed, m_kind, m_zc, m_oc, m_err;
    int m_hold, m_led, m_riseq, m_len, m_max;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_yd = 0; m_zd = 0; m_armed = 0; m_kind = 0;
        m_zc = 0; m_oc = 0; m_err = 0; m_hold = 0;
        m_led = 0; m_riseq = 0; m_len = 0; m_max = 0;
    endtask

    task automatic m_step(input int zv, input int yv, input int cv);
        int rise, cls, nk;
        exp_t e;
        rise = (zv != 0 && m_zd == 0 && m_armed != 0) ? 1 : 0;
        cls  = (m_yd == 4) ? 1 : (m_yd == 8) ? 2 : 3;
        if (m_kind == 0) nk = rise ? cls : 0;
        else             nk = zv ? m_kind : 0;
        if (m_kind != 0 && zv == 0) begin
            if (m_len > m_max) m_max = m_len;
            m_len = 0;
        end else if (rise != 0) begin
            m_len = 1;
        end else if (m_kind != 0 && m_len < CMAX) begin
            m_len++;
        end
        if (cv != 0) m_max = 0;
        if (cv != 0) begin
            m_zc = 0; m_oc = 0; m_err = 0;
        end else if (rise != 0) begin
            if (cls == 1 && m_zc < CMAX) m_zc++;
            if (cls == 2 && m_oc < CMAX) m_oc++;
            if (cls == 3) m_err = 1;
        end
        if (m_riseq != 0) begin
            m_hold = HOLD_CYC - 1; m_led = 1;
        end else if (m_hold > 0) begin
            m_hold--; m_led = 1;
        end else begin
            m_led = 0;
        end
        m_riseq = rise;
        m_kind  = nk;
        m_zd    = zv;
        m_yd    = yv & 15;
        if (zv == 0) m_armed = 1;
        e.zc = m_zc; e.oc = m_oc; e.led = m_led;
        e.kind = m_kind; e.err = m_err; e.mx = m_max;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int zv, input int yv, input int cv);
        exp_t e;
        @(negedge clk);
        bus.z   = zv[0];
        bus.y   = yv[8:0];
        bus.clr = cv[0];
        m_step(zv, yv, cv);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("zero_cnt", 32'(bus.zero_cnt), e.zc);
        chk("one_cnt", 32'(bus.one_cnt), e.oc);
        chk("match_led", 32'(bus.match_led), e.led);
        chk("match_kind", 32'(bus.match_kind), e.kind);
        chk("err", 32'(bus.err), e.err);
`ifdef MATCH_STATS_EN
        chk("max_len", 32'(bus.max_len), e.mx);
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_zero_cnt"}, 32'(bus.zero_cnt), 0);
        chk({tag, "_one_cnt"}, 32'(bus.one_cnt), 0);
        chk({tag, "_led"}, 32'(bus.match_led), 0);
        chk({tag, "_kind"}, 32'(bus.match_kind), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        bus.z   = 1'b0;
        bus.y   = '0;
        bus.clr = 1'b0;
        m_reset();
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        cyc(0, 4, 0); cyc(0, 4, 0);
        repeat (3) cyc(1, 0, 0);
        repeat (14) cyc(0, 0, 0);
        chk("zrun_zero_cnt", 32'(bus.zero_cnt), 1);
        chk("zrun_one_cnt", 32'(bus.one_cnt), 0);

        cyc(0, 8, 0);
        repeat (2) cyc(1, 0, 0);
        cyc(0, 8, 0);
        repeat (2) cyc(1, 0, 0);
        repeat (14) cyc(0, 0, 0);
        chk("orun_one_cnt", 32'(bus.one_cnt), 2);

        repeat (300) begin
            cyc(0, 4, 0);
            cyc(1, 4, 0);
        end
        cyc(0, 0, 0);
        chk("sat_zero_cnt", 32'(bus.zero_cnt), 255);

        cyc(0, 3, 0);
        cyc(1, 0, 0);
        chk("uncl_kind", 32'(bus.match_kind), 3);
        chk("uncl_err", 32'(bus.err), 1);
        chk("uncl_one_cnt", 32'(bus.one_cnt), 2);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        chk("clr_err", 32'(bus.err), 0);
        chk("clr_zero_cnt", 32'(bus.zero_cnt), 0);
        chk("clr_one_cnt", 32'(bus.one_cnt), 0);

        cyc(0, 4, 0);
        cyc(1, 0, 1);
        chk("clrrise_kind", 32'(bus.match_kind), 1);
        cyc(0, 0, 0);
        chk("clrrise_zero_cnt", 32'(bus.zero_cnt), 0);

        cyc(0, 4, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        #3;
        reset = 1'b0;
        #1;
        chk_zero("midrst");
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) cyc(1, 4, 0);
        chk("held_zero_cnt", 32'(bus.zero_cnt), 0);
        chk("held_kind", 32'(bus.match_kind), 0);
        cyc(0, 4, 0);
        cyc(1, 4, 0);
        cyc(0, 0, 0);
        chk("rearm_zero_cnt", 32'(bus.zero_cnt), 1);

        foreach (exp_q[i]) chk("queue_empty", 1, 0);
        begin
            int lens[3];
            lens = '{2, 5, 3};
            foreach (lens[i]) begin
                cyc(0, 4, 0);
                repeat (lens[i]) cyc(1, 0, 0);
            end
            cyc(0, 0, 0);
            cyc(0, 0, 0);
        end
`ifdef MATCH_STATS_EN
        chk("stats_max_len", 32'(bus.max_len), 5);
`endif
        chk("stats_zero_cnt", 32'(bus.zero_cnt), 4);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
